// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flow controller for a five-stage pipeline.
// Drives PC enable/select and the IF/ID, ID/EX, EX/MEM, MEM/WB stage-register
// controls. It handles data-memory waits with a timeout, EX branches,
// load-use stalls, IRQ entry and ID jumps, and keeps saturating stall and
// flush counters.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_RUN    | normal flow; the per-cycle priority rules pick the controls
// ST_MEM_WAIT | data memory is busy; the whole pipe is frozen until ready or
//           | until wait_cnt reaches MEM_TIMEOUT

module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int STAT_W      = 16
) (
   input  logic              reset,
   input  logic              clk,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_jump,
   input  logic              id_noirq,
   input  logic              ex_memrd,
   input  logic [4:0]        ex_rt,
   input  logic              ex_br_taken,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic              mem_ready,
   input  logic              irq,
   input  logic              eret,
   output logic              pc_en,
   output logic [1:0]        pc_sel,
   output logic [1:0]        ifid_src,
   output logic              idex_stall,
   output logic              front_en,
   output logic              back_en,
   output logic              epc_wr,
   output logic              irq_ack,
   output logic              mem_err,
   output logic [STAT_W-1:0] stall_cnt,
   output logic [STAT_W-1:0] flush_cnt
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

   localparam logic [1:0] PC_SEL_SEQ  = 2'd0;
   localparam logic [1:0] PC_SEL_JMP  = 2'd1;
   localparam logic [1:0] PC_SEL_BR   = 2'd2;
   localparam logic [1:0] PC_SEL_IRQ  = 2'd3;
   localparam logic [1:0] SRC_PASS    = 2'd0;
   localparam logic [1:0] SRC_BUBBLE  = 2'd1;
   localparam logic [1:0] SRC_HOLD    = 2'd2;

   typedef enum logic {ST_RUN, ST_MEM_WAIT} state_t;

   state_t            state_q, state_d;
   logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic              in_irq_q, in_irq_d;
   logic              irq_pend_q, irq_pend_d;
   logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic mem_busy;
   logic load_use;
   logic frozen;
   logic redirect;

   assign mem_busy = (mem_rd | mem_wr) & ~mem_ready;
   assign load_use = ex_memrd & (ex_rt != 5'd0) &
                     ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));

   // Next state, wait timer, IRQ bookkeeping and the per-cycle output priority.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      in_irq_d    = in_irq_q;
      irq_pend_d  = irq_pend_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      frozen      = 1'b0;
      redirect    = 1'b0;
      pc_en       = 1'b1;
      pc_sel      = PC_SEL_SEQ;
      ifid_src    = SRC_PASS;
      idex_stall  = 1'b0;
      front_en    = 1'b1;
      back_en     = 1'b1;
      epc_wr      = 1'b0;
      irq_ack     = 1'b0;
      mem_err     = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_busy) begin
               frozen     = 1'b1;
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WC_W'(1);
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
               // give up on the access and let the pipe move again this cycle
               mem_err    = 1'b1;
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else begin
               frozen     = 1'b1;
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase

      if (frozen) begin
         pc_en    = 1'b0;
         ifid_src = SRC_HOLD;
         front_en = 1'b0;
         back_en  = 1'b0;
      end else if (ex_br_taken) begin
         pc_sel     = PC_SEL_BR;
         ifid_src   = SRC_BUBBLE;
         idex_stall = 1'b1;
         redirect   = 1'b1;
      end else if (load_use) begin
         pc_en      = 1'b0;
         ifid_src   = SRC_HOLD;
         idex_stall = 1'b1;
      end else if (irq_pend_q & ~in_irq_q & id_noirq) begin
         pc_sel     = PC_SEL_IRQ;
         ifid_src   = SRC_BUBBLE;
         idex_stall = 1'b1;
         epc_wr     = 1'b1;
         irq_ack    = 1'b1;
         redirect   = 1'b1;
      end else if (id_jump) begin
         pc_sel   = PC_SEL_JMP;
         ifid_src = SRC_BUBBLE;
         redirect = 1'b1;
      end

      if (irq & ~in_irq_q) irq_pend_d = 1'b1;
      if (irq_ack)         irq_pend_d = 1'b0;

      // an ack in the same cycle as eret re-enters the handler
      if (eret)    in_irq_d = 1'b0;
      if (irq_ack) in_irq_d = 1'b1;

      if (!pc_en && (stall_cnt_q != STAT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (redirect && (flush_cnt_q != STAT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;

      // while reset is held the outputs show the idle, PC-halted controls
      if (!reset) begin
         pc_en      = 1'b0;
         pc_sel     = PC_SEL_SEQ;
         ifid_src   = SRC_PASS;
         idex_stall = 1'b0;
         front_en   = 1'b1;
         back_en    = 1'b1;
         epc_wr     = 1'b0;
         irq_ack    = 1'b0;
         mem_err    = 1'b0;
      end
   end

   // State, timer, IRQ flags and statistics registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         in_irq_q    <= 1'b0;
         irq_pend_q  <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         in_irq_q    <= in_irq_d;
         irq_pend_q  <= irq_pend_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a cycle-level
// behavioural model of the stall/flush/IRQ rules.

module tb_pipe_hazard_ctrl;

   localparam int TO     = 64;
   localparam int SW     = 6;
   localparam int SMAX   = (1 << SW) - 1;

   logic          reset, clk;
   logic [4:0]    id_rs, id_rt, ex_rt;
   logic          id_uses_rs, id_uses_rt, id_jump, id_noirq;
   logic          ex_memrd, ex_br_taken, mem_rd, mem_wr, mem_ready, irq, eret;
   logic          pc_en, idex_stall, front_en, back_en, epc_wr, irq_ack, mem_err;
   logic [1:0]    pc_sel, ifid_src;
   logic [SW-1:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // model state
   bit m_wait;
   int m_wcnt;
   bit m_in_irq, m_pend;
   int m_stall, m_flush;
   bit last_ack, last_err;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .STAT_W(SW)) dut (
      .reset(reset), .clk(clk),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_jump(id_jump), .id_noirq(id_noirq), .ex_memrd(ex_memrd), .ex_rt(ex_rt),
      .ex_br_taken(ex_br_taken), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready),
      .irq(irq), .eret(eret),
      .pc_en(pc_en), .pc_sel(pc_sel), .ifid_src(ifid_src), .idex_stall(idex_stall),
      .front_en(front_en), .back_en(back_en), .epc_wr(epc_wr), .irq_ack(irq_ack),
      .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      id_rs = 0; id_rt = 0; ex_rt = 0;
      id_uses_rs = 0; id_uses_rt = 0; id_jump = 0; id_noirq = 0;
      ex_memrd = 0; ex_br_taken = 0; mem_rd = 0; mem_wr = 0; mem_ready = 1;
      irq = 0; eret = 0;
   endtask

   function automatic logic [10:0] pack_out(bit pe, int ps, int src, bit st, bit fe, bit be,
                                            bit ew, bit ack, bit err);
      return {pe, 2'(ps), 2'(src), st, fe, be, ew, ack, err};
   endfunction

   // Called shortly after a rising edge with inputs already applied.
   task automatic apply_reset();
      reset = 1'b0;
      #2;
      check_val("rst_outputs", 32'({pc_en, pc_sel, ifid_src, idex_stall, front_en, back_en,
                                    epc_wr, irq_ack, mem_err}),
                32'(pack_out(0, 0, 0, 0, 1, 1, 0, 0, 0)));
      @(posedge clk); #1;
      check_val("rst_stall_cnt", 32'(stall_cnt), 0);
      check_val("rst_flush_cnt", 32'(flush_cnt), 0);
      reset = 1'b1;
      m_wait = 0; m_wcnt = 0; m_in_irq = 0; m_pend = 0; m_stall = 0; m_flush = 0;
   endtask

   // One clock: predict combinational outputs, compare, advance model, compare counters.
   task automatic step(input string tag);
      bit frozen, err, lu, redir;
      bit pe, st, fe, be, ew, ack;
      int ps, src;
      #2;
      frozen = 0; err = 0; redir = 0;
      pe = 1; ps = 0; src = 0; st = 0; fe = 1; be = 1; ew = 0; ack = 0;
      if (m_wait) begin
         if (mem_ready) frozen = 0;
         else if (m_wcnt == TO) err = 1;
         else frozen = 1;
      end else begin
         frozen = (mem_rd || mem_wr) && !mem_ready;
      end
      lu = ex_memrd && ex_rt != 0 &&
           ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
      if (frozen) begin
         pe = 0; src = 2; fe = 0; be = 0;
      end else if (ex_br_taken) begin
         ps = 2; src = 1; st = 1; redir = 1;
      end else if (lu) begin
         pe = 0; src = 2; st = 1;
      end else if (m_pend && !m_in_irq && id_noirq) begin
         ps = 3; src = 1; st = 1; ew = 1; ack = 1; redir = 1;
      end else if (id_jump) begin
         ps = 1; src = 1; redir = 1;
      end
      check_val({tag, "_outs"},
                32'({pc_en, pc_sel, ifid_src, idex_stall, front_en, back_en, epc_wr, irq_ack, mem_err}),
                32'(pack_out(pe, ps, src, st, fe, be, ew, ack, err)));
      last_ack = irq_ack;
      last_err = mem_err;

      if (frozen) begin
         if (m_wait) m_wcnt++;
         else begin m_wait = 1; m_wcnt = 1; end
      end else begin
         m_wait = 0; m_wcnt = 0;
      end
      if (ack) m_pend = 0;
      else if (irq && !m_in_irq) m_pend = 1;
      if (ack) m_in_irq = 1;
      else if (eret) m_in_irq = 0;
      if (!pe && m_stall < SMAX) m_stall++;
      if (redir && m_flush < SMAX) m_flush++;

      @(posedge clk); #1;
      check_val({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
      check_val({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
   endtask

   initial begin
      int acks, err_cycle;
      reset = 1'b0;
      idle_inputs();
      @(posedge clk); #1;
      apply_reset();

      // load-use on rs
      ex_memrd = 1; ex_rt = 5; id_uses_rs = 1; id_rs = 5;
      step("lu");
      check_val("lu_stall_one", 32'(stall_cnt), 1);
      // same registers but destination r0: no hazard
      ex_rt = 0;
      step("lu_r0");
      idle_inputs();
      // branch and jump together: branch wins, one flush
      ex_br_taken = 1; id_jump = 1;
      step("br_jmp");
      check_val("br_jmp_flush_one", 32'(flush_cnt), 1);
      idle_inputs();

      // three-cycle memory wait
      apply_reset();
      mem_rd = 1; mem_ready = 0;
      for (int i = 0; i < 3; i++) step("mwait");
      mem_ready = 1;
      step("mwait_rel");
      check_val("mwait_stall3", 32'(stall_cnt), 3);
      idle_inputs();

      // memory timeout
      apply_reset();
      mem_wr = 1; mem_ready = 0;
      err_cycle = -1;
      for (int i = 1; i <= TO + 1 && err_cycle < 0; i++) begin
         step("mto");
         if (last_err) err_cycle = i;
      end
      check_val("mto_err_cycle", 32'(err_cycle), 32'(TO + 1));
      idle_inputs();
      step("mto_after");
      check_val("mto_back_en", 32'(back_en), 1);

      // IRQ entry, second IRQ masked until eret
      apply_reset();
      acks = 0;
      irq = 1; id_noirq = 0;
      for (int i = 0; i < 2; i++) begin step("irq_blk"); acks += int'(last_ack); end
      id_noirq = 1;
      for (int i = 0; i < 5; i++) begin step("irq_in"); acks += int'(last_ack); end
      check_val("irq_one_ack", 32'(acks), 1);
      irq = 0; eret = 1;
      step("eret");
      eret = 0; irq = 1;
      acks = 0;
      for (int i = 0; i < 3; i++) begin step("irq_again"); acks += int'(last_ack); end
      check_val("irq_reack", 32'(acks), 1);
      idle_inputs();

      // randomized traffic, periodic resets (some land mid-wait)
      apply_reset();
      for (int i = 0; i < 1500; i++) begin
         id_rs       = 5'($urandom_range(0, 3));
         id_rt       = 5'($urandom_range(0, 3));
         ex_rt       = 5'($urandom_range(0, 3));
         id_uses_rs  = 1'($urandom);
         id_uses_rt  = 1'($urandom);
         id_jump     = ($urandom_range(0, 3) == 0);
         id_noirq    = 1'($urandom);
         ex_memrd    = 1'($urandom);
         ex_br_taken = ($urandom_range(0, 4) == 0);
         mem_rd      = ($urandom_range(0, 3) == 0);
         mem_wr      = ($urandom_range(0, 5) == 0);
         mem_ready   = ($urandom_range(0, 2) != 0);
         irq         = ($urandom_range(0, 3) == 0);
         eret        = ($urandom_range(0, 15) == 0);
         step("rnd");
         if (i % 200 == 199) apply_reset();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
